arm_multicycle_ctrl: RTL

//  Multicycle sequencer for the ARM core; replaces the single-cycle controller when datapath shares one memory/ALU.

---
 rtl/arm_mc_pkg.sv | 61 ++++++
 rtl/arm_cond_unit.sv | 59 +++++
 rtl/arm_multicycle_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/arm_mc_pkg.sv
// Shared types and encodings for the ARM multicycle controller.
// State enum, ALU/mux select codes, instruction field codes and condition codes.
package arm_mc_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXECR  = 4'd2,
        EXECI  = 4'd3,
        ALUWB  = 4'd4,
        MEMADR = 4'd5,
        MEMRD  = 4'd6,
        MEMWB  = 4'd7,
        MEMWR  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_CMP = 4'b1010;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

endpackage

// File: rtl/arm_cond_unit.sv
// NZCV flags register and condition evaluation for the multicycle controller.
// Ports: clk, reset (async active-low), cond, ALUFlags, FlagW {NZ,CV} -> CondEx.
module arm_cond_unit
    import arm_mc_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    output logic       CondEx
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       n;
    logic       z;
    logic       c;
    logic       v;

    assign {n, z, c, v} = flags_q;

    // cond=1111 falls to default and never executes
    always_comb begin
        CondEx = 1'b0;
        case (cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = (n == v);
            COND_LT: CondEx = (n != v);
            COND_GT: CondEx = ~z & (n == v);
            COND_LE: CondEx = z | (n != v);
            COND_AL: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

    always_comb begin
        flags_d = flags_q;
        if (CondEx && FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
        if (CondEx && FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) flags_q <= RESET_FLAGS;
        else        flags_q <= flags_d;
    end

endmodule

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM sequencer: FSM over FETCH..BRANCH issuing enables and mux selects.
// Ports: clk, reset (async active-low), Instr[31:12], ALUFlags -> datapath controls, State.
module arm_multicycle_ctrl
    import arm_mc_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUControl,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic        RegWrite,
    output logic [3:0]  State
);

    state_t     state_q;
    state_t     state_d;
    logic       ce_q;
    logic       ce_d;
    logic       cond_ex;
    logic [1:0] flag_w;
    logic       pc_w;
    logic       mem_w;
    logic       ir_w;
    logic       reg_w;

    logic [1:0] op;
    logic [3:0] cmd;
    logic       i_bit;
    logic       s_bit;
    logic       u_bit;
    logic       l_bit;
    logic       rd_pc;
    logic       flag_en;
    logic [2:0] dp_alu;
    logic       dp_wr;
    logic       dp_cv;
    logic       unused_rn;

    assign op        = Instr[15:14];
    assign i_bit     = Instr[13];
    assign cmd       = Instr[12:9];
    assign u_bit     = Instr[11];
    assign s_bit     = Instr[8];
    assign l_bit     = Instr[8];
    assign rd_pc     = (Instr[3:0] == 4'hF);
    assign unused_rn = ^Instr[7:4];
    assign flag_en   = s_bit | (cmd == CMD_CMP);

    arm_cond_unit #(
        .RESET_FLAGS(RESET_FLAGS)
    ) u_cond (
        .clk     (clk),
        .reset   (reset),
        .cond    (Instr[19:16]),
        .ALUFlags(ALUFlags),
        .FlagW   (flag_w),
        .CondEx  (cond_ex)
    );

    always_comb begin
        dp_alu = ALU_ADD;
        dp_wr  = 1'b0;
        dp_cv  = 1'b1;
        case (cmd)
            CMD_ADD: dp_wr = 1'b1;
            CMD_SUB: begin dp_alu = ALU_SUB; dp_wr = 1'b1; end
            CMD_AND: begin dp_alu = ALU_AND; dp_wr = 1'b1; dp_cv = 1'b0; end
            CMD_ORR: begin dp_alu = ALU_ORR; dp_wr = 1'b1; dp_cv = 1'b0; end
            CMD_CMP: dp_alu = ALU_SUB;
            default: dp_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        ImmSrc = IMM_DP;
        case (op)
            OP_MEM:  ImmSrc = IMM_MEM;
            OP_BR:   ImmSrc = IMM_BR;
            default: ImmSrc = IMM_DP;
        endcase
    end

    assign RegSrc = {(op == OP_MEM) & ~l_bit, (op == OP_BR)};

    // Condition is sampled in DECODE, before this instruction can touch the
    // flags, so the write-back states see pre-instruction flags.
    assign ce_d = (state_q == DECODE) ? cond_ex : ce_q;

    always_comb begin
        state_d    = state_q;
        pc_w       = 1'b0;
        mem_w      = 1'b0;
        ir_w       = 1'b0;
        reg_w      = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_WD;
        ALUControl = ALU_ADD;
        flag_w     = 2'b00;
        case (state_q)
            FETCH: begin
                ir_w      = 1'b1;
                pc_w      = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                state_d   = DECODE;
            end
            DECODE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_FOUR;
                case (op)
                    OP_DP:   state_d = i_bit ? EXECI : EXECR;
                    OP_MEM:  state_d = MEMADR;
                    OP_BR:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            EXECR: begin
                ALUControl = dp_alu;
                flag_w     = {flag_en, flag_en & dp_cv};
                state_d    = ALUWB;
            end
            EXECI: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = dp_alu;
                flag_w     = {flag_en, flag_en & dp_cv};
                state_d    = ALUWB;
            end
            ALUWB: begin
                reg_w   = ce_q & ~rd_pc & dp_wr;
                pc_w    = ce_q & rd_pc;
                state_d = FETCH;
            end
            MEMADR: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = u_bit ? ALU_ADD : ALU_SUB;
                state_d    = l_bit ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc  = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                ResultSrc = RES_DATA;
                reg_w     = ce_q & ~rd_pc;
                pc_w      = ce_q & rd_pc;
                state_d   = FETCH;
            end
            MEMWR: begin
                AdrSrc  = 1'b1;
                mem_w   = ce_q;
                state_d = FETCH;
            end
            BRANCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALU;
                pc_w      = ce_q;
                state_d   = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // Enables are forced low combinationally while reset is held.
    assign PCWrite  = pc_w & reset;
    assign MemWrite = mem_w & reset;
    assign IRWrite  = ir_w & reset;
    assign RegWrite = reg_w & reset;
    assign State    = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            ce_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ce_q    <= ce_d;
        end
    end

endmodule
